// File: rtl/multicore_nios_cpu_debug_ocimem_seq_if.sv
// Debug RAM request/response bus between the OCI memory sequencer and the RAM.
interface multicore_nios_cpu_debug_ocimem_seq_if #(
    parameter int unsigned ADDR_W = 9
);
    logic              mem_req;
    logic              mem_wr;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wrdata;
    logic [31:0]       mem_rddata;
    logic              mem_ack;

    modport master (
        output mem_req,
        output mem_wr,
        output mem_addr,
        output mem_wrdata,
        input  mem_rddata,
        input  mem_ack
    );

    modport slave (
        input  mem_req,
        input  mem_wr,
        input  mem_addr,
        input  mem_wrdata,
        output mem_rddata,
        output mem_ack
    );
endinterface

// File: rtl/multicore_nios_cpu_debug_ocimem_seq.sv
// Sequences JTAG debug commands into single debug-RAM reads/writes with
// auto-incrementing address, ack timeout and sticky status flags.
module multicore_nios_cpu_debug_ocimem_seq #(
    parameter int unsigned ADDR_W  = 9,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [37:0] jdo,
    input  logic        take_action_ocimem_a,
    input  logic        take_action_ocimem_b,
    input  logic        take_no_action_ocimem_a,
    multicore_nios_cpu_debug_ocimem_seq_if.master mem,
    output logic [31:0] MonDReg,
    output logic        monitor_ready,
    output logic        monitor_error,
    output logic        cmd_overrun
);

    localparam int unsigned CNT_W = 8;
    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RD_REQ   = 2'd1,
        WR_REQ   = 2'd2,
        ERR_HOLD = 2'd3
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] wait_cnt;
    logic             any_strobe_c;

    // jdo carries fields for other debug stages; only the address, read flag and data are used here
    wire unused_jdo = &{1'b0, jdo[37:35], jdo[2:0]};

    assign any_strobe_c = take_action_ocimem_a | take_action_ocimem_b | take_no_action_ocimem_a;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state          <= IDLE;
            wait_cnt       <= '0;
            mem.mem_req    <= 1'b0;
            mem.mem_wr     <= 1'b0;
            mem.mem_addr   <= '0;
            mem.mem_wrdata <= '0;
            MonDReg        <= '0;
            monitor_ready  <= 1'b0;
            monitor_error  <= 1'b0;
            cmd_overrun    <= 1'b0;
        end else begin
            case (state)
                // Strobe priority: write, then address load, then read-at-current-address
                IDLE: begin
                    if (take_action_ocimem_b) begin
                        mem.mem_wrdata <= jdo[34:3];
                        mem.mem_req    <= 1'b1;
                        mem.mem_wr     <= 1'b1;
                        wait_cnt       <= '0;
                        monitor_ready  <= 1'b0;
                        state          <= WR_REQ;
                    end else if (take_action_ocimem_a) begin
                        mem.mem_addr  <= ADDR_W'(jdo[25:17]);
                        monitor_error <= 1'b0;
                        cmd_overrun   <= 1'b0;
                        if (jdo[34]) begin
                            mem.mem_req   <= 1'b1;
                            wait_cnt      <= '0;
                            monitor_ready <= 1'b0;
                            state         <= RD_REQ;
                        end else begin
                            monitor_ready <= 1'b1;
                        end
                    end else if (take_no_action_ocimem_a) begin
                        mem.mem_req   <= 1'b1;
                        wait_cnt      <= '0;
                        monitor_ready <= 1'b0;
                        state         <= RD_REQ;
                    end
                end

                // Ack takes precedence over a timeout landing on the same cycle
                RD_REQ, WR_REQ: begin
                    if (any_strobe_c) begin
                        cmd_overrun <= 1'b1;
                    end
                    if (mem.mem_ack) begin
                        if (state == RD_REQ) begin
                            MonDReg <= mem.mem_rddata;
                        end
                        mem.mem_addr  <= mem.mem_addr + ADDR_W'(1);
                        mem.mem_req   <= 1'b0;
                        mem.mem_wr    <= 1'b0;
                        monitor_ready <= 1'b1;
                        state         <= IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                        if (wait_cnt == WAIT_LAST) begin
                            mem.mem_req   <= 1'b0;
                            mem.mem_wr    <= 1'b0;
                            monitor_error <= 1'b1;
                            state         <= ERR_HOLD;
                        end
                    end
                end

                ERR_HOLD: begin
                    if (any_strobe_c) begin
                        cmd_overrun <= 1'b1;
                    end
                    state <= IDLE;
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_multicore_nios_cpu_debug_ocimem_seq.sv
// Scoreboard bench for the OCI memory sequencer: reads, writes, wrap, timeout,
// strobe priority, overrun and mid-request reset.
module tb_multicore_nios_cpu_debug_ocimem_seq;

    typedef struct packed {
        logic [31:0] mon;
        logic [8:0]  addr;
        logic        rdy;
        logic        err;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [37:0] jdo;
    logic        take_action_ocimem_a;
    logic        take_action_ocimem_b;
    logic        take_no_action_ocimem_a;
    logic [31:0] MonDReg;
    logic        monitor_ready;
    logic        monitor_error;
    logic        cmd_overrun;

    int   checks = 0;
    int   errors = 0;
    int   wr_count = 0;
    logic [8:0]  last_wr_addr;
    logic [31:0] last_wr_data;
    exp_t exp_q[$];

    multicore_nios_cpu_debug_ocimem_seq_if #(.ADDR_W(9)) mem ();

    multicore_nios_cpu_debug_ocimem_seq #(
        .ADDR_W (9),
        .TIMEOUT(255)
    ) dut (
        .clk                    (clk),
        .reset_n                (reset_n),
        .jdo                    (jdo),
        .take_action_ocimem_a   (take_action_ocimem_a),
        .take_action_ocimem_b   (take_action_ocimem_b),
        .take_no_action_ocimem_a(take_no_action_ocimem_a),
        .mem                    (mem.master),
        .MonDReg                (MonDReg),
        .monitor_ready          (monitor_ready),
        .monitor_error          (monitor_error),
        .cmd_overrun            (cmd_overrun)
    );

    always #5 clk = ~clk;

    // Records each write that the RAM acknowledges
    always @(posedge clk) begin
        if (mem.mem_req && mem.mem_wr && mem.mem_ack) begin
            wr_count     <= wr_count + 1;
            last_wr_addr <= mem.mem_addr;
            last_wr_data <= mem.mem_wrdata;
        end
    end

    function automatic exp_t obs();
        return {MonDReg, mem.mem_addr, monitor_ready, monitor_error};
    endfunction

    function automatic logic [37:0] mk_a(input logic [8:0] addr, input logic rd);
        logic [37:0] j;
        j = '0;
        j[25:17] = addr;
        j[34] = rd;
        return j;
    endfunction

    function automatic logic [37:0] mk_b(input logic [31:0] data);
        logic [37:0] j;
        j = '0;
        j[34:3] = data;
        return j;
    endfunction

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic pulse(input logic a, input logic b, input logic n, input logic [37:0] j);
        jdo = j;
        take_action_ocimem_a = a;
        take_action_ocimem_b = b;
        take_no_action_ocimem_a = n;
        @(negedge clk);
        take_action_ocimem_a = 1'b0;
        take_action_ocimem_b = 1'b0;
        take_no_action_ocimem_a = 1'b0;
    endtask

    task automatic ack(input logic [31:0] d);
        mem.mem_rddata = d;
        mem.mem_ack = 1'b1;
        @(negedge clk);
        mem.mem_ack = 1'b0;
        mem.mem_rddata = '0;
    endtask

    task automatic test_reset();
        logic [80:0] outs;
        reset_n = 1'b0;
        jdo = '0;
        take_action_ocimem_a = 1'b0;
        take_action_ocimem_b = 1'b0;
        take_no_action_ocimem_a = 1'b0;
        mem.mem_ack = 1'b0;
        mem.mem_rddata = '0;
        repeat (3) tick();
        outs = {mem.mem_req, mem.mem_wr, mem.mem_addr, mem.mem_wrdata, MonDReg,
                monitor_ready, monitor_error, cmd_overrun};
        checks++;
        if (outs !== '0) begin
            errors++;
            $display("FAIL reset_values got %h exp 0", outs);
        end
        reset_n = 1'b1;
        tick();
        outs = {mem.mem_req, mem.mem_wr, mem.mem_addr, mem.mem_wrdata, MonDReg,
                monitor_ready, monitor_error, cmd_overrun};
        checks++;
        if (outs !== '0) begin
            errors++;
            $display("FAIL idle_after_release got %h exp 0", outs);
        end
    endtask

    task automatic test_read();
        exp_t e;
        pulse(1'b1, 1'b0, 1'b0, mk_a(9'h010, 1'b1));
        exp_q.push_back('{mon: 32'hDEADBEEF, addr: 9'h011, rdy: 1'b1, err: 1'b0});
        checks++;
        if ({mem.mem_req, mem.mem_wr, mem.mem_addr, monitor_ready} !== {1'b1, 1'b0, 9'h010, 1'b0}) begin
            errors++;
            $display("FAIL read_issue got req=%b wr=%b addr=%h rdy=%b exp 1 0 010 0",
                     mem.mem_req, mem.mem_wr, mem.mem_addr, monitor_ready);
        end
        tick();
        tick();
        checks++;
        if ({mem.mem_req, mem.mem_addr} !== {1'b1, 9'h010}) begin
            errors++;
            $display("FAIL read_hold got req=%b addr=%h exp 1 010", mem.mem_req, mem.mem_addr);
        end
        ack(32'hDEADBEEF);
        e = exp_q.pop_front();
        checks++;
        if (obs() !== e || mem.mem_req !== 1'b0) begin
            errors++;
            $display("FAIL read_done got %h req=%b exp %h req=0", obs(), mem.mem_req, e);
        end
    endtask

    task automatic test_load_only();
        pulse(1'b1, 1'b0, 1'b0, mk_a(9'h1FF, 1'b0));
        checks++;
        if (obs() !== exp_t'({32'hDEADBEEF, 9'h1FF, 1'b1, 1'b0}) || mem.mem_req !== 1'b0) begin
            errors++;
            $display("FAIL load_only got %h req=%b exp deadbeef/1ff/1/0 req=0", obs(), mem.mem_req);
        end
    endtask

    task automatic test_write_wrap();
        exp_t e;
        int   w0;
        w0 = wr_count;
        pulse(1'b0, 1'b1, 1'b0, mk_b(32'h12345678));
        exp_q.push_back('{mon: 32'hDEADBEEF, addr: 9'h000, rdy: 1'b1, err: 1'b0});
        checks++;
        if ({mem.mem_req, mem.mem_wr, mem.mem_addr, mem.mem_wrdata, monitor_ready} !==
            {1'b1, 1'b1, 9'h1FF, 32'h12345678, 1'b0}) begin
            errors++;
            $display("FAIL write_issue got req=%b wr=%b addr=%h data=%h rdy=%b exp 1 1 1ff 12345678 0",
                     mem.mem_req, mem.mem_wr, mem.mem_addr, mem.mem_wrdata, monitor_ready);
        end
        ack(32'hFFFFFFFF);
        e = exp_q.pop_front();
        checks++;
        if (obs() !== e || mem.mem_wr !== 1'b0) begin
            errors++;
            $display("FAIL write_done got %h wr=%b exp %h wr=0", obs(), mem.mem_wr, e);
        end
        checks++;
        if (wr_count - w0 != 1 || last_wr_addr !== 9'h1FF || last_wr_data !== 32'h12345678) begin
            errors++;
            $display("FAIL write_count got n=%0d addr=%h data=%h exp 1 1ff 12345678",
                     wr_count - w0, last_wr_addr, last_wr_data);
        end
    endtask

    task automatic test_timeout();
        exp_t e;
        int   n;
        pulse(1'b0, 1'b0, 1'b1, '0);
        exp_q.push_back('{mon: 32'hDEADBEEF, addr: 9'h000, rdy: 1'b0, err: 1'b1});
        n = 0;
        while (mem.mem_req === 1'b1 && n < 400) begin
            n++;
            tick();
        end
        checks++;
        if (n != 255) begin
            errors++;
            $display("FAIL timeout_len got %0d exp 255", n);
        end
        e = exp_q.pop_front();
        checks++;
        if (obs() !== e) begin
            errors++;
            $display("FAIL timeout_status got %h exp %h", obs(), e);
        end
        tick();
        pulse(1'b0, 1'b0, 1'b1, '0);
        exp_q.push_back('{mon: 32'hCAFEF00D, addr: 9'h001, rdy: 1'b1, err: 1'b1});
        checks++;
        if ({mem.mem_req, cmd_overrun, mem.mem_addr, monitor_ready} !== {1'b1, 1'b0, 9'h000, 1'b0}) begin
            errors++;
            $display("FAIL after_err_hold got req=%b ovr=%b addr=%h rdy=%b exp 1 0 000 0",
                     mem.mem_req, cmd_overrun, mem.mem_addr, monitor_ready);
        end
        ack(32'hCAFEF00D);
        e = exp_q.pop_front();
        checks++;
        if (obs() !== e) begin
            errors++;
            $display("FAIL retry_read got %h exp %h", obs(), e);
        end
    endtask

    task automatic test_priority();
        exp_t        e;
        logic [31:0] d;
        d = 32'hA5A50F0F;
        pulse(1'b1, 1'b1, 1'b0, mk_b(d));
        exp_q.push_back('{mon: 32'hCAFEF00D, addr: 9'h002, rdy: 1'b1, err: 1'b1});
        checks++;
        if ({mem.mem_req, mem.mem_wr, mem.mem_addr, mem.mem_wrdata, cmd_overrun} !==
            {1'b1, 1'b1, 9'h001, d, 1'b0}) begin
            errors++;
            $display("FAIL priority_issue got req=%b wr=%b addr=%h data=%h ovr=%b exp 1 1 001 %h 0",
                     mem.mem_req, mem.mem_wr, mem.mem_addr, mem.mem_wrdata, cmd_overrun, d);
        end
        ack(32'h0);
        e = exp_q.pop_front();
        checks++;
        if (obs() !== e || cmd_overrun !== 1'b0) begin
            errors++;
            $display("FAIL priority_done got %h ovr=%b exp %h ovr=0", obs(), cmd_overrun, e);
        end
    endtask

    task automatic test_overrun();
        exp_t e;
        pulse(1'b1, 1'b0, 1'b0, mk_a(9'h020, 1'b1));
        exp_q.push_back('{mon: 32'h0BADF00D, addr: 9'h021, rdy: 1'b1, err: 1'b0});
        checks++;
        if ({mem.mem_req, monitor_error, cmd_overrun} !== 3'b100) begin
            errors++;
            $display("FAIL ovr_issue got req=%b err=%b ovr=%b exp 1 0 0",
                     mem.mem_req, monitor_error, cmd_overrun);
        end
        pulse(1'b0, 1'b0, 1'b1, '0);
        checks++;
        if ({mem.mem_req, mem.mem_addr, cmd_overrun} !== {1'b1, 9'h020, 1'b1}) begin
            errors++;
            $display("FAIL ovr_set got req=%b addr=%h ovr=%b exp 1 020 1",
                     mem.mem_req, mem.mem_addr, cmd_overrun);
        end
        ack(32'h0BADF00D);
        e = exp_q.pop_front();
        checks++;
        if (obs() !== e || cmd_overrun !== 1'b1 || mem.mem_req !== 1'b0) begin
            errors++;
            $display("FAIL ovr_sticky got %h ovr=%b req=%b exp %h ovr=1 req=0",
                     obs(), cmd_overrun, mem.mem_req, e);
        end
        pulse(1'b1, 1'b0, 1'b0, mk_a(9'h030, 1'b0));
        checks++;
        if ({cmd_overrun, monitor_ready, mem.mem_addr} !== {1'b0, 1'b1, 9'h030}) begin
            errors++;
            $display("FAIL ovr_clear got ovr=%b rdy=%b addr=%h exp 0 1 030",
                     cmd_overrun, monitor_ready, mem.mem_addr);
        end
    endtask

    task automatic test_back_to_back();
        exp_t        e;
        logic [31:0] d;
        for (int i = 0; i < 3; i++) begin
            d = $urandom;
            pulse(1'b0, 1'b0, 1'b1, '0);
            exp_q.push_back('{mon: d, addr: 9'(9'h031 + i), rdy: 1'b1, err: 1'b0});
            checks++;
            if ({mem.mem_req, mem.mem_addr, monitor_ready} !== {1'b1, 9'(9'h030 + i), 1'b0}) begin
                errors++;
                $display("FAIL b2b_issue%0d got req=%b addr=%h rdy=%b", i,
                         mem.mem_req, mem.mem_addr, monitor_ready);
            end
            ack(d);
            e = exp_q.pop_front();
            checks++;
            if (obs() !== e || cmd_overrun !== 1'b0) begin
                errors++;
                $display("FAIL b2b_done%0d got %h ovr=%b exp %h ovr=0", i, obs(), cmd_overrun, e);
            end
        end
    endtask

    task automatic test_reset_mid();
        exp_t        e;
        logic [80:0] outs;
        pulse(1'b0, 1'b1, 1'b0, mk_b(32'h55AA55AA));
        checks++;
        if ({mem.mem_req, mem.mem_wr} !== 2'b11) begin
            errors++;
            $display("FAIL rst_mid_issue got req=%b wr=%b exp 1 1", mem.mem_req, mem.mem_wr);
        end
        #2 reset_n = 1'b0;
        #1;
        outs = {mem.mem_req, mem.mem_wr, mem.mem_addr, mem.mem_wrdata, MonDReg,
                monitor_ready, monitor_error, cmd_overrun};
        checks++;
        if (outs !== '0) begin
            errors++;
            $display("FAIL rst_async got %h exp 0", outs);
        end
        @(negedge clk);
        mem.mem_ack = 1'b1;
        take_no_action_ocimem_a = 1'b1;
        @(negedge clk);
        take_no_action_ocimem_a = 1'b0;
        reset_n = 1'b1;
        tick();
        mem.mem_ack = 1'b0;
        outs = {mem.mem_req, mem.mem_wr, mem.mem_addr, mem.mem_wrdata, MonDReg,
                monitor_ready, monitor_error, cmd_overrun};
        checks++;
        if (outs !== '0) begin
            errors++;
            $display("FAIL rst_late_ack got %h exp 0", outs);
        end
        pulse(1'b1, 1'b0, 1'b0, mk_a(9'h0AB, 1'b1));
        exp_q.push_back('{mon: 32'h13579BDF, addr: 9'h0AC, rdy: 1'b1, err: 1'b0});
        checks++;
        if ({mem.mem_req, mem.mem_addr} !== {1'b1, 9'h0AB}) begin
            errors++;
            $display("FAIL rst_first_strobe got req=%b addr=%h exp 1 0ab", mem.mem_req, mem.mem_addr);
        end
        ack(32'h13579BDF);
        e = exp_q.pop_front();
        checks++;
        if (obs() !== e) begin
            errors++;
            $display("FAIL rst_recover got %h exp %h", obs(), e);
        end
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_read();
        test_load_only();
        test_write_wrap();
        test_timeout();
        test_priority();
        test_overrun();
        test_back_to_back();
        test_reset_mid();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_left got %0d exp 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/multicore_nios_cpu_debug_ocimem_seq.md
MULTICORE_NIOS_CPU_DEBUG_OCIMEM_SEQ -- requirements
Module: multicore_nios_cpu_debug_ocimem_seq

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 9, meaning the word-address width of the debug RAM.
REQ-002 The block SHALL have parameter TIMEOUT, default 255, meaning the maximum cycles to wait for mem_ack, range 1..255.
REQ-003 The block SHALL have port clk, input, 1, the single system clock; all logic is on its rising edge.
REQ-004 The block SHALL have port reset_n, input, 1, the asynchronous active-low reset.
REQ-005 The block SHALL have port jdo, input, 38, the debug command word from the debug slave sysclk stage.
REQ-006 The block SHALL have ports take_action_ocimem_a, take_action_ocimem_b and take_no_action_ocimem_a, input, 1 each, single-cycle command strobes.
REQ-007 The block SHALL have port mem_rddata, input, 32, the debug RAM read data, valid in the cycle mem_ack is high.
REQ-008 The block SHALL have port mem_ack, input, 1, the debug RAM completion strobe.
REQ-009 The block SHALL have ports mem_req (1), mem_wr (1), mem_addr (ADDR_W) and mem_wrdata (32), all outputs, forming the debug RAM request.
REQ-010 The block SHALL have port MonDReg, output, 32, the last read data, returned to the debug slave.
REQ-011 The block SHALL have ports monitor_ready (1), monitor_error (1) and cmd_overrun (1), all outputs, for status.

Function
REQ-012 The FSM SHALL have states IDLE, RD_REQ, WR_REQ and ERR_HOLD, which are the only states.
REQ-013 Only in IDLE, take_action_ocimem_a SHALL load mem_addr from jdo[25:17]; if jdo[34]=1, it SHALL also go to RD_REQ, otherwise it SHALL stay in IDLE and assert monitor_ready.
REQ-014 Only in IDLE, take_no_action_ocimem_a SHALL go to RD_REQ at the current mem_addr.
REQ-015 Only in IDLE, take_action_ocimem_b SHALL load mem_wrdata from jdo[34:3] and go to WR_REQ at the current mem_addr.
REQ-016 If more than one strobe is high in the same IDLE cycle, the priority SHALL be ocimem_b, then ocimem_a, then no_action_a, and the losing strobes SHALL be dropped without setting cmd_overrun.
REQ-017 Any strobe received outside IDLE SHALL be ignored and SHALL set cmd_overrun, which stays sticky until the next accepted take_action_ocimem_a.
REQ-018 In RD_REQ and WR_REQ, mem_req SHALL be 1, and mem_wr SHALL be 1 only in WR_REQ; mem_addr and mem_wrdata SHALL be stable while mem_req=1.
REQ-019 mem_req SHALL rise on the cycle after the accepting strobe, so request latency is 1 clock.
REQ-020 When mem_ack=1 in RD_REQ, MonDReg SHALL capture mem_rddata on the same edge.
REQ-021 When mem_ack=1 in RD_REQ or WR_REQ, the block SHALL increment mem_addr by 1 modulo 2^ADDR_W (so 2^ADDR_W-1 wraps to 0), set monitor_ready, and go to IDLE.
REQ-022 mem_ack received in IDLE or ERR_HOLD SHALL be ignored.
REQ-023 A wait counter SHALL be cleared on entry to RD_REQ or WR_REQ and increment once per cycle without mem_ack.
REQ-024 When the wait counter reaches TIMEOUT, the block SHALL deassert mem_req, set monitor_error, leave mem_addr and MonDReg unchanged, and go to ERR_HOLD.
REQ-025 ERR_HOLD SHALL last exactly 1 cycle and then go to IDLE, with monitor_ready remaining 0.
REQ-026 monitor_ready SHALL clear on the cycle after any accepted strobe.
REQ-027 monitor_error SHALL clear on the next accepted take_action_ocimem_a.
REQ-028 If mem_ack arrives on the same cycle the counter reaches TIMEOUT, the ack SHALL win and be treated as normal completion.

Reset
REQ-029 On reset_n=0, asynchronously: state=IDLE; mem_req=0, mem_wr=0; mem_addr=0; mem_wrdata=0; MonDReg=0; monitor_ready=0, monitor_error=0, cmd_overrun=0; wait counter=0.
REQ-030 A reset asserted mid-request SHALL drop mem_req immediately and abandon the transaction, with no completion reported.
REQ-031 After reset release, the first strobe SHALL be honoured only if it occurs on or after the first rising edge with reset_n=1.

Verification
REQ-032 Bench scenario: ocimem_a with jdo[25:17]=9'h010 and jdo[34]=1, mem_ack after 3 cycles with rddata=32'hDEADBEEF -> MonDReg=DEADBEEF, mem_addr=9'h011, monitor_ready=1.
REQ-033 Bench scenario: ocimem_b with jdo[34:3]=32'h12345678 at mem_addr=9'h1FF, mem_ack after 1 cycle -> one write with mem_wr=1 and wrdata 12345678 at 1FF, then mem_addr=0.
REQ-034 Bench scenario: read issued with no mem_ack and TIMEOUT=255 -> mem_req high for exactly 255 cycles, monitor_error=1, 1 cycle of ERR_HOLD, then IDLE with mem_addr unchanged.
REQ-035 Bench scenario: ocimem_a and ocimem_b pulsed together in IDLE -> write executed, no address load, cmd_overrun=0.
REQ-036 Bench scenario: no_action_a pulsed during RD_REQ -> ignored, cmd_overrun=1, and it remains 1 after completion until the next ocimem_a.
REQ-037 Bench scenario: reset_n pulsed low during WR_REQ -> mem_req=0 within the same cycle and all outputs at reset values; a later ack is ignored.
